// File: rtl/dcache_responder_if.sv
// Request/response bundle between the LSU data-cache port and its memory-side responder.
// The LSU side drives the request fields; the responder returns line data and status.
interface dcache_responder_if;
    logic         DCACHE_EN;
    logic         DCACHE_RW;
    logic [31:0]  DCACHE_ADDR;
    logic [3:0]   DCACHE_SIZE;
    logic [63:0]  DCACHE_WR_DATA;
    logic [127:0] DCACHE_RD_DATA;
    logic         DCACHE_READY;
    logic         DCACHE_ERR;
    logic         BUSY;

    modport master (
        output DCACHE_EN, DCACHE_RW, DCACHE_ADDR, DCACHE_SIZE, DCACHE_WR_DATA,
        input  DCACHE_RD_DATA, DCACHE_READY, DCACHE_ERR, BUSY
    );

    modport slave (
        input  DCACHE_EN, DCACHE_RW, DCACHE_ADDR, DCACHE_SIZE, DCACHE_WR_DATA,
        output DCACHE_RD_DATA, DCACHE_READY, DCACHE_ERR, BUSY
    );
endinterface

// File: rtl/dcache_responder.sv
// Fixed-latency data-cache stand-in: one request at a time against an array of 16-byte lines,
// completing with a one-cycle READY pulse that carries the whole (possibly updated) line.
module dcache_responder #(
    parameter int LINES   = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    dcache_responder_if.slave bus
);
    localparam int         IDXW     = $clog2(LINES);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } StateT;

    StateT            r_state;
    StateT            w_nextState;

    logic [3:0]       r_cnt;
    logic             r_rw;
    logic [IDXW-1:0]  r_index;
    logic [3:0]       r_offset;
    logic [3:0]       r_size;
    logic [63:0]      r_wrData;
    logic [127:0]     r_rdData;
    logic             r_err;
    logic [127:0]     r_mem [LINES];

    logic             w_capture;
    logic             w_finish;
    logic             w_illegal;
    logic             w_memWrite;
    logic [4:0]       w_endSum;
    logic [15:0]      w_byteEn;
    logic [127:0]     w_line;
    logic [127:0]     w_shifted;
    logic [127:0]     w_merged;
    logic             w_unusedAddr;

    assign w_unusedAddr = ^bus.DCACHE_ADDR[31:4+IDXW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Capture always passes through WAIT so the access commits on the edge that raises READY,
    // which keeps the LATENCY edges between capture and READY even when LATENCY is 1.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.DCACHE_EN) begin
                    w_capture   = 1'b1;
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_finish    = 1'b1;
                    w_nextState = RESP;
                end
            end
            RESP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_endSum  = {1'b0, r_offset} + {1'b0, r_size};
        w_illegal = (r_size == 4'd0) || (r_size > 4'd8) || (w_endSum > 5'd16);
        w_byteEn  = 16'((17'd1 << r_size) - 17'd1) << r_offset;
        w_shifted = {64'h0, r_wrData} << {r_offset, 3'b000};
        w_line    = r_mem[r_index];
        w_merged  = w_line;
        for (int b = 0; b < 16; b++) begin
            if (w_byteEn[b]) begin
                w_merged[b*8 +: 8] = w_shifted[b*8 +: 8];
            end
        end
        w_memWrite = w_finish && r_rw && !w_illegal && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_rw     <= 1'b0;
            r_index  <= '0;
            r_offset <= 4'd0;
            r_size   <= 4'd0;
            r_wrData <= 64'h0;
            r_rdData <= 128'h0;
            r_err    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cnt    <= CNT_INIT;
                r_rw     <= bus.DCACHE_RW;
                r_index  <= bus.DCACHE_ADDR[4+IDXW-1:4];
                r_offset <= bus.DCACHE_ADDR[3:0];
                r_size   <= bus.DCACHE_SIZE;
                r_wrData <= bus.DCACHE_WR_DATA;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_finish) begin
                r_rdData <= (r_rw && !w_illegal) ? w_merged : w_line;
                r_err    <= w_illegal;
            end
        end
    end

    // Line storage is deliberately left out of reset so preloaded contents survive it.
    always_ff @(posedge clk) begin
        if (w_memWrite) begin
            r_mem[r_index] <= w_merged;
        end
    end

    assign bus.DCACHE_RD_DATA = r_rdData;
    assign bus.DCACHE_READY   = (r_state == RESP);
    assign bus.DCACHE_ERR     = (r_state == RESP) && r_err;
    assign bus.BUSY           = (r_state != IDLE);
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a vector table of single requests on a LATENCY=4 instance,
// plus hand-written reset, back-to-back/aliasing and LATENCY=1 sequences.
module tb_dcache_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dcache_responder_if bus4();
    dcache_responder_if bus1();

    dcache_responder #(.LINES(16), .LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    dcache_responder #(.LINES(16), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [3:0]   size;
        logic [63:0]  wrData;
        int           idx;
        logic [127:0] preload;
        logic [127:0] expLine;
        logic         expErr;
    } VecT;

    VecT vecs[12];

    task automatic checkOutput(input string what, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", what, actual, expected);
        end
    endtask

    // Issues one request on the LATENCY=4 instance and waits (bounded) for its READY pulse.
    task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [3:0] size,
                                 input logic [63:0] wrData, output int latency,
                                 output logic [127:0] rd, output logic err, output logic busyOk);
        bus4.DCACHE_EN      = 1'b1;
        bus4.DCACHE_RW      = rw;
        bus4.DCACHE_ADDR    = addr;
        bus4.DCACHE_SIZE    = size;
        bus4.DCACHE_WR_DATA = wrData;
        @(posedge clk);
        #1;
        bus4.DCACHE_EN = 1'b0;
        latency = 0;
        busyOk  = bus4.BUSY;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus4.DCACHE_READY) begin
                latency = n;
                break;
            end
            if (!bus4.BUSY || bus4.DCACHE_ERR) busyOk = 1'b0;
        end
        rd     = bus4.DCACHE_RD_DATA;
        err    = bus4.DCACHE_ERR;
        busyOk = busyOk & bus4.BUSY;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int           latency;
        logic [127:0] rd;
        logic         err;
        logic         busyOk;
        logic [127:0] pat;
        logic         sawReady;

        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b0, 32'h0000002A, 4'd4, 64'h0, 2,
                     128'hDEADBEEFCAFEBABEDEADBEEFCAFEBABE, 128'hDEADBEEFCAFEBABEDEADBEEFCAFEBABE, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000001C, 4'd4, 64'hDEADBEEFCAFEBABE, 1,
                     128'h0, 128'hCAFEBABE000000000000000000000000, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000001F, 4'd2, 64'hFFFF, 1,
                     128'h00112233445566778899AABBCCDDEEFF, 128'h00112233445566778899AABBCCDDEEFF, 1'b1};
        vecs[3]  = '{1'b0, 32'h00000020, 4'd0, 64'h0, 2,
                     128'h0F0E0D0C0B0A09080706050403020100, 128'h0F0E0D0C0B0A09080706050403020100, 1'b1};
        vecs[4]  = '{1'b1, 32'h00000020, 4'd9, 64'h1111, 2,
                     128'h0F0E0D0C0B0A09080706050403020100, 128'h0F0E0D0C0B0A09080706050403020100, 1'b1};
        vecs[5]  = '{1'b1, 32'h00000030, 4'd8, 64'h0123456789ABCDEF, 3,
                     128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'hFFFFFFFFFFFFFFFF0123456789ABCDEF, 1'b0};
        vecs[6]  = '{1'b1, 32'h00000038, 4'd8, 64'h0123456789ABCDEF, 3,
                     128'h0, 128'h0123456789ABCDEF0000000000000000, 1'b0};
        vecs[7]  = '{1'b1, 32'h00000039, 4'd8, 64'h0123456789ABCDEF, 3,
                     128'h1, 128'h1, 1'b1};
        vecs[8]  = '{1'b1, 32'h10000045, 4'd1, 64'hFFFFFFFFFFFFFFA5, 4,
                     128'h0, 128'h0000A50000000000, 1'b0};
        vecs[9]  = '{1'b1, 32'h000000F0, 4'd3, 64'h0000000000112233, 15,
                     128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFF112233, 1'b0};
        vecs[10] = '{1'b0, 32'hABCD0130, 4'd8, 64'h0, 3,
                     128'h123456789ABCDEF00FEDCBA987654321, 128'h123456789ABCDEF00FEDCBA987654321, 1'b0};
        vecs[11] = '{1'b1, 32'h0000005F, 4'd1, 64'h77, 5,
                     128'h0, 128'h77000000000000000000000000000000, 1'b0};

        bus4.DCACHE_EN = 1'b0; bus4.DCACHE_RW = 1'b0; bus4.DCACHE_ADDR = 32'h0;
        bus4.DCACHE_SIZE = 4'd0; bus4.DCACHE_WR_DATA = 64'h0;
        bus1.DCACHE_EN = 1'b0; bus1.DCACHE_RW = 1'b0; bus1.DCACHE_ADDR = 32'h0;
        bus1.DCACHE_SIZE = 4'd0; bus1.DCACHE_WR_DATA = 64'h0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset READY", 128'(bus4.DCACHE_READY), 128'h0);
        checkOutput("reset ERR", 128'(bus4.DCACHE_ERR), 128'h0);
        checkOutput("reset BUSY", 128'(bus4.BUSY), 128'h0);
        checkOutput("reset RD_DATA", bus4.DCACHE_RD_DATA, 128'h0);
        checkOutput("reset lat1 outputs", {bus1.DCACHE_RD_DATA[124:0], bus1.DCACHE_READY, bus1.DCACHE_ERR, bus1.BUSY}, 128'h0);

        // Reset held together with EN must win: nothing is captured on that edge.
        bus4.DCACHE_EN = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus4.DCACHE_EN = 1'b0;
        checkOutput("rst over EN BUSY", 128'(bus4.BUSY), 128'h0);
        @(posedge clk);
        #1;
        checkOutput("rst over EN idle", 128'(bus4.BUSY), 128'h0);

        for (int i = 0; i < 12; i++) begin
            dut4.r_mem[vecs[i].idx] = vecs[i].preload;
            applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].size, vecs[i].wrData, latency, rd, err, busyOk);
            checkOutput($sformatf("vec%0d latency", i), 128'(latency), 128'd4);
            checkOutput($sformatf("vec%0d RD_DATA", i), rd, vecs[i].expLine);
            checkOutput($sformatf("vec%0d ERR", i), 128'(err), 128'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d BUSY", i), 128'(busyOk), 128'h1);
            checkOutput($sformatf("vec%0d MEM", i), dut4.r_mem[vecs[i].idx], vecs[i].expLine);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d after READY", i),
                        128'({bus4.DCACHE_READY, bus4.DCACHE_ERR, bus4.BUSY}), 128'h0);
        end

        // Aliased write with EN held high, then a read queued while the write is still responding.
        dut4.r_mem[2] = 128'hDEADBEEFCAFEBABEDEADBEEFCAFEBABE;
        applyStimulus(1'b1, 32'h0200002A, 4'd1, 64'h5A, latency, rd, err, busyOk);
        bus4.DCACHE_EN   = 1'b1;
        bus4.DCACHE_RW   = 1'b0;
        bus4.DCACHE_ADDR = 32'h0000002A;
        bus4.DCACHE_SIZE = 4'd4;
        checkOutput("b2b write latency", 128'(latency), 128'd4);
        checkOutput("b2b write RD_DATA", rd, 128'hDEADBEEFCA5ABABEDEADBEEFCAFEBABE);
        @(posedge clk);
        #1;
        checkOutput("b2b idle gap", 128'({bus4.DCACHE_READY, bus4.BUSY}), 128'h0);
        latency = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus4.DCACHE_READY) begin
                latency = n;
                break;
            end
        end
        bus4.DCACHE_EN = 1'b0;
        checkOutput("b2b read spacing", 128'(latency), 128'd5);
        checkOutput("b2b read RD_DATA", bus4.DCACHE_RD_DATA, 128'hDEADBEEFCA5ABABEDEADBEEFCAFEBABE);
        checkOutput("b2b read byte10", 128'(bus4.DCACHE_RD_DATA[87:80]), 128'h5A);
        @(posedge clk);
        #1;

        // Reset lands two cycles into a write; the write must vanish without trace.
        pat = 128'hA5A5A5A55A5A5A5AA5A5A5A55A5A5A5A;
        dut4.r_mem[5] = pat;
        bus4.DCACHE_EN      = 1'b1;
        bus4.DCACHE_RW      = 1'b1;
        bus4.DCACHE_ADDR    = 32'h00000050;
        bus4.DCACHE_SIZE    = 4'd8;
        bus4.DCACHE_WR_DATA = 64'h1122334455667788;
        @(posedge clk);
        #1;
        bus4.DCACHE_EN = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid-reset outputs", 128'({bus4.DCACHE_READY, bus4.DCACHE_ERR, bus4.BUSY}), 128'h0);
        checkOutput("mid-reset RD_DATA", bus4.DCACHE_RD_DATA, 128'h0);
        sawReady = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus4.DCACHE_READY || bus4.BUSY) sawReady = 1'b1;
        end
        checkOutput("mid-reset no READY", 128'(sawReady), 128'h0);
        checkOutput("mid-reset MEM", dut4.r_mem[5], pat);
        applyStimulus(1'b0, 32'h00000050, 4'd8, 64'h0, latency, rd, err, busyOk);
        checkOutput("post-reset latency", 128'(latency), 128'd4);
        checkOutput("post-reset RD_DATA", rd, pat);
        checkOutput("post-reset ERR", 128'(err), 128'h0);
        @(posedge clk);
        #1;

        // Same read on the LATENCY=1 instance.
        dut1.r_mem[2] = 128'hDEADBEEFCAFEBABEDEADBEEFCAFEBABE;
        bus1.DCACHE_EN   = 1'b1;
        bus1.DCACHE_RW   = 1'b0;
        bus1.DCACHE_ADDR = 32'h0000002A;
        bus1.DCACHE_SIZE = 4'd4;
        @(posedge clk);
        #1;
        bus1.DCACHE_EN = 1'b0;
        checkOutput("lat1 BUSY after capture", 128'({bus1.BUSY, bus1.DCACHE_READY}), 128'h2);
        latency = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus1.DCACHE_READY) begin
                latency = n;
                break;
            end
        end
        checkOutput("lat1 latency", 128'(latency), 128'd1);
        checkOutput("lat1 RD_DATA", bus1.DCACHE_RD_DATA, 128'hDEADBEEFCAFEBABEDEADBEEFCAFEBABE);
        checkOutput("lat1 ERR", 128'(bus1.DCACHE_ERR), 128'h0);
        @(posedge clk);
        #1;
        checkOutput("lat1 after READY", 128'({bus1.DCACHE_READY, bus1.BUSY}), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
